// File: rtl/la_iosidectl_pkg.sv
// rtl/la_iosidectl_pkg.sv - shared definitions for the IO side power/enable controller
// Holds the sequencer state encoding and the width of one pin-to-section map field.
package la_iosidectl_pkg;

   localparam int PINSEC_W = 8;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_PUP   = 3'd1,
      ST_ON    = 3'd2,
      ST_DRAIN = 3'd3,
      ST_PDN   = 3'd4
   } side_state_e;

endpackage

// File: rtl/la_iodelaycnt.sv
// rtl/la_iodelaycnt.sv - loadable down-counter timing each power section's settle period
// Load wins over decrement; the count holds at zero.
module la_iodelaycnt #(
   parameter int DLYW = 8
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            load_i,
   input  logic            dec_i,
   input  logic [DLYW-1:0] load_val_i,
   output logic            zero_o
);

   logic [DLYW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (dec_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - DLYW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/la_iosidectl.sv
// rtl/la_iosidectl.sv - sequences power sections of one IO side and gates per-pin ie/oe
// Sections come up low-to-high and go down high-to-low; pins only drive while fully ON.
module la_iosidectl
   import la_iosidectl_pkg::*;
#(
   parameter int                        NPINS     = 8,
   parameter int                        NSECTIONS = 2,
   parameter int                        CFGW      = 4,
   parameter int                        DLYW      = 8,
   parameter logic [NPINS*PINSEC_W-1:0] PINSEC    = '0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  shutdown,
   input  logic [DLYW-1:0]       dly,
   input  logic                  wr_valid,
   output logic                  wr_ready,
   input  logic [7:0]            wr_addr,
   input  logic                  wr_ie,
   input  logic                  wr_oe,
   input  logic [CFGW-1:0]       wr_cfg,
   output logic [NPINS-1:0]      ie,
   output logic [NPINS-1:0]      oe,
   output logic [NPINS*CFGW-1:0] cfg,
   output logic [NSECTIONS-1:0]  sec_en,
   output logic                  busy,
   output logic                  done,
   output logic                  err
);

   localparam logic [7:0] LAST_SEC = 8'(NSECTIONS - 1);

   side_state_e            state_q, state_d;
   logic [7:0]             idx_q, idx_d;
   logic [NSECTIONS-1:0]   sec_en_q, sec_en_d;
   logic                   err_q;
   logic                   cnt_load, cnt_dec, cnt_zero;
   logic                   is_on;

   function automatic logic [NSECTIONS-1:0] sec_write(input logic [NSECTIONS-1:0] v,
                                                       input logic [7:0] i,
                                                       input logic b);
      sec_write = v;
      for (int s = 0; s < NSECTIONS; s++) begin
         if (i == 8'(s)) sec_write[s] = b;
      end
   endfunction

   la_iodelaycnt #(.DLYW(DLYW)) u_dlycnt (
      .clk        (clk),
      .reset      (reset),
      .load_i     (cnt_load),
      .dec_i      (cnt_dec),
      .load_val_i (dly),
      .zero_o     (cnt_zero)
   );

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      sec_en_d = sec_en_q;
      cnt_load = 1'b0;
      cnt_dec  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d  = ST_PUP;
               idx_d    = '0;
               sec_en_d = sec_write(sec_en_q, 8'd0, 1'b1);
               cnt_load = 1'b1;
            end
         end
         ST_PUP: begin
            // An abort keeps the current index so power-down starts at the highest live section
            if (shutdown) begin
               state_d = ST_DRAIN;
            end else if (cnt_zero) begin
               if (idx_q == LAST_SEC) begin
                  state_d = ST_ON;
               end else begin
                  idx_d    = idx_q + 8'd1;
                  sec_en_d = sec_write(sec_en_q, idx_q + 8'd1, 1'b1);
                  cnt_load = 1'b1;
               end
            end else begin
               cnt_dec = 1'b1;
            end
         end
         ST_ON: begin
            if (shutdown) begin
               state_d = ST_DRAIN;
               idx_d   = LAST_SEC;
            end
         end
         ST_DRAIN: begin
            state_d  = ST_PDN;
            cnt_load = 1'b1;
         end
         ST_PDN: begin
            if (cnt_zero) begin
               sec_en_d = sec_write(sec_en_q, idx_q, 1'b0);
               if (idx_q == 8'd0) begin
                  state_d = ST_IDLE;
               end else begin
                  idx_d    = idx_q - 8'd1;
                  cnt_load = 1'b1;
               end
            end else begin
               cnt_dec = 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         idx_q    <= '0;
         sec_en_q <= '0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         sec_en_q <= sec_en_d;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         err_q <= 1'b0;
      end else if (wr_valid && (wr_addr >= 8'(NPINS))) begin
         err_q <= 1'b1;
      end
   end

   assign is_on    = (state_q == ST_ON);
   assign wr_ready = 1'b1;
   assign sec_en   = sec_en_q;
   assign busy     = (state_q == ST_PUP) || (state_q == ST_DRAIN) || (state_q == ST_PDN);
   assign done     = is_on;
   assign err      = err_q;

   for (genvar p = 0; p < NPINS; p++) begin : g_pin
      // Pins mapped to a section number beyond NSECTIONS get an empty mask and stay gated off
      localparam logic [NSECTIONS-1:0] SEC_MASK =
         NSECTIONS'(1) << PINSEC[p*PINSEC_W +: PINSEC_W];

      logic            ie_q, oe_q;
      logic [CFGW-1:0] cfg_q;
      logic            wr_hit;
      logic            sec_live;

      assign wr_hit   = wr_valid && (wr_addr == 8'(p));
      assign sec_live = |(sec_en_q & SEC_MASK);

      always_ff @(posedge clk) begin
         if (reset) begin
            ie_q  <= 1'b0;
            oe_q  <= 1'b0;
            cfg_q <= '0;
         end else if (wr_hit) begin
            ie_q  <= wr_ie;
            oe_q  <= wr_oe;
            cfg_q <= wr_cfg;
         end
      end

      assign ie[p]                 = ie_q & sec_live & is_on;
      assign oe[p]                 = oe_q & sec_live & is_on;
      assign cfg[p*CFGW +: CFGW]   = cfg_q;
   end

endmodule

// File: tb/tb_la_iosidectl.sv
// tb/tb_la_iosidectl.sv - self-checking bench for la_iosidectl
// Timeline model of the section sequence plus directed literal checks.
module tb_la_iosidectl;

   localparam int NP = 8;
   localparam int NS = 2;
   localparam int CW = 4;
   localparam int DW = 8;
   localparam logic [NP*8-1:0] PSEC_P = {8'd1, 8'd1, 8'd1, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0};
   localparam int M_IDLE = 0, M_UP = 1, M_ON = 2, M_DRAIN = 3, M_DOWN = 4;

   logic              clk = 1'b0;
   logic              reset, start, shutdown, wr_valid, wr_ready, wr_ie, wr_oe;
   logic [7:0]        wr_addr;
   logic [DW-1:0]     dly;
   logic [CW-1:0]     wr_cfg;
   logic [NP-1:0]     ie, oe;
   logic [NP*CW-1:0]  cfg;
   logic [NS-1:0]     sec_en;
   logic              busy, done, err;

   int checks = 0;
   int errors = 0;
   int psec[NP] = '{0, 0, 0, 0, 1, 1, 1, 1};

   always #5 clk = ~clk;

   la_iosidectl #(
      .NPINS(NP), .NSECTIONS(NS), .CFGW(CW), .DLYW(DW), .PINSEC(PSEC_P)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .shutdown(shutdown), .dly(dly),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_ie(wr_ie),
      .wr_oe(wr_oe), .wr_cfg(wr_cfg), .ie(ie), .oe(oe), .cfg(cfg), .sec_en(sec_en),
      .busy(busy), .done(done), .err(err)
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h want %0h", nm, $time, act, exp);
      end
   endtask

   // Model: count of live sections plus the absolute edge at which the next step happens
   int          edge_n = 0;
   int          m_mode = M_IDLE;
   int          m_non = 0;
   int          m_next = 0;
   bit          m_err = 0;
   bit          m_live = 0;
   bit          m_ie[NP];
   bit          m_oe[NP];
   logic [CW-1:0] m_cfg[NP];

   always @(posedge clk) begin : model
      int e;
      e = edge_n + 1;
      edge_n <= e;
      if (reset) begin
         m_mode <= M_IDLE;
         m_non  <= 0;
         m_err  <= 0;
         m_live <= 1;
         for (int p = 0; p < NP; p++) begin
            m_ie[p]  <= 0;
            m_oe[p]  <= 0;
            m_cfg[p] <= '0;
         end
      end else begin
         if (wr_valid) begin
            if (wr_addr < NP) begin
               m_ie[wr_addr[2:0]]  <= wr_ie;
               m_oe[wr_addr[2:0]]  <= wr_oe;
               m_cfg[wr_addr[2:0]] <= wr_cfg;
            end else begin
               m_err <= 1;
            end
         end
         case (m_mode)
            M_IDLE: if (start) begin
               m_mode <= M_UP;
               m_non  <= 1;
               m_next <= e + int'(dly) + 1;
            end
            M_UP: begin
               if (shutdown) m_mode <= M_DRAIN;
               else if (e == m_next) begin
                  if (m_non < NS) begin
                     m_non  <= m_non + 1;
                     m_next <= e + int'(dly) + 1;
                  end else begin
                     m_mode <= M_ON;
                  end
               end
            end
            M_ON: if (shutdown) m_mode <= M_DRAIN;
            M_DRAIN: begin
               m_mode <= M_DOWN;
               m_next <= e + int'(dly) + 1;
            end
            M_DOWN: if (e == m_next) begin
               m_non <= m_non - 1;
               if (m_non == 1) m_mode <= M_IDLE;
               else m_next <= e + int'(dly) + 1;
            end
            default: m_mode <= M_IDLE;
         endcase
      end
   end

   always @(negedge clk) begin : compare
      logic [NS-1:0]    x_sec;
      logic [NP-1:0]    x_ie, x_oe;
      logic [NP*CW-1:0] x_cfg;
      if (m_live) begin
         x_sec = NS'((1 << m_non) - 1);
         for (int p = 0; p < NP; p++) begin
            x_ie[p] = m_ie[p] && (m_mode == M_ON) && (psec[p] < m_non);
            x_oe[p] = m_oe[p] && (m_mode == M_ON) && (psec[p] < m_non);
            x_cfg[p*CW +: CW] = m_cfg[p];
         end
         chk("m_sec_en", sec_en, x_sec);
         chk("m_ie", ie, x_ie);
         chk("m_oe", oe, x_oe);
         chk("m_cfg", cfg, x_cfg);
         chk("m_busy", busy, (m_mode == M_UP) || (m_mode == M_DRAIN) || (m_mode == M_DOWN));
         chk("m_done", done, m_mode == M_ON);
         chk("m_err", err, m_err);
         chk("m_wr_ready", wr_ready, 1'b1);
      end
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic write(input logic [7:0] a, input logic i, input logic o, input logic [CW-1:0] c);
      wr_valid = 1'b1;
      wr_addr  = a;
      wr_ie    = i;
      wr_oe    = o;
      wr_cfg   = c;
      tick();
      wr_valid = 1'b0;
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; shutdown = 1'b0; dly = '0;
      wr_valid = 1'b0; wr_addr = '0; wr_ie = 1'b0; wr_oe = 1'b0; wr_cfg = '0;
      tick();
      chk("rst_sec_en", sec_en, 2'b00);
      chk("rst_busy", busy, 1'b0);
      chk("rst_err", err, 1'b0);
      tick();
      reset = 1'b0;

      write(8'd2, 1'b1, 1'b1, 4'hA);
      chk("wr_cfg2", cfg[11:8], 4'hA);
      chk("wr_ie2_gated", ie[2], 1'b0);
      write(8'd5, 1'b1, 1'b0, 4'h3);

      dly = 8'd3;
      start = 1'b1; tick(); start = 1'b0;
      chk("pup_c1_sec", sec_en, 2'b01);
      repeat (3) tick();
      chk("pup_c4_sec", sec_en, 2'b01);
      tick();
      chk("pup_c5_sec", sec_en, 2'b11);
      chk("pup_c5_ie2", ie[2], 1'b0);
      repeat (3) tick();
      chk("pup_c8_done", done, 1'b0);
      tick();
      chk("pup_c9_done", done, 1'b1);
      chk("on_ie2", ie[2], 1'b1);
      chk("on_oe2", oe[2], 1'b1);
      chk("on_ie5", ie[5], 1'b1);
      chk("on_oe5", oe[5], 1'b0);

      start = 1'b1; tick(); start = 1'b0;
      chk("on_start_ignored", done, 1'b1);
      write(8'd0, 1'b1, 1'b1, 4'h5);
      chk("on_ie0", ie[0], 1'b1);

      dly = 8'd1;
      shutdown = 1'b1; tick(); shutdown = 1'b0;
      chk("drain_ie", ie, 8'h00);
      chk("drain_oe", oe, 8'h00);
      chk("drain_sec", sec_en, 2'b11);
      repeat (2) tick();
      chk("pdn_t3_sec", sec_en, 2'b11);
      tick();
      chk("pdn_t4_sec", sec_en, 2'b01);
      repeat (2) tick();
      chk("pdn_t6_sec", sec_en, 2'b00);
      chk("pdn_t6_busy", busy, 1'b0);

      dly = 8'd2;
      start = 1'b1; tick(); start = 1'b0;
      shutdown = 1'b1; tick(); shutdown = 1'b0;
      chk("abort_sec", sec_en, 2'b01);
      chk("abort_busy", busy, 1'b1);
      repeat (3) tick();
      chk("abort_c5_sec", sec_en, 2'b01);
      tick();
      chk("abort_c6_sec", sec_en, 2'b00);
      chk("abort_c6_busy", busy, 1'b0);

      write(8'd8, 1'b0, 1'b0, 4'hF);
      chk("bad_err", err, 1'b1);
      chk("bad_cfg2", cfg[11:8], 4'hA);
      write(8'd255, 1'b0, 1'b0, 4'hF);
      repeat (3) tick();
      chk("bad_err_sticky", err, 1'b1);

      dly = 8'd0;
      start = 1'b1; shutdown = 1'b1; tick(); start = 1'b0; shutdown = 1'b0;
      chk("both_sec", sec_en, 2'b01);
      tick();
      chk("d0_sec", sec_en, 2'b11);
      tick();
      chk("d0_done", done, 1'b1);
      shutdown = 1'b1; tick(); shutdown = 1'b0;
      repeat (4) tick();
      chk("d0_down_sec", sec_en, 2'b00);
      shutdown = 1'b1; tick(); shutdown = 1'b0;
      chk("idle_shutdown_ignored", busy, 1'b0);

      dly = 8'd5;
      start = 1'b1; tick(); start = 1'b0;
      repeat (2) tick();
      reset = 1'b1; tick(); reset = 1'b0;
      chk("rstmid_sec", sec_en, 2'b00);
      chk("rstmid_busy", busy, 1'b0);
      chk("rstmid_err", err, 1'b0);
      chk("rstmid_cfg", cfg, 32'h0);
      start = 1'b1; tick(); start = 1'b0;
      chk("restart_sec", sec_en, 2'b01);
      repeat (12) tick();
      chk("restart_done", done, 1'b1);
      repeat (3) tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
